// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave byte engine.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

  localparam int SPI_DEFAULT_WIDTH = 8;

  // Mode 0: SCLK idles low, sample on rising edge, shift on falling edge.
  localparam bit         SPI_CPOL = 1'b0;
  localparam bit         SPI_CPHA = 1'b0;
  localparam logic [1:0] SPI_MODE = {SPI_CPOL, SPI_CPHA};

endpackage

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave word engine: assembles MSB-first RX words, shifts TX words onto MISO.
// All inputs are already synchronized into sysClk_i; SCLK/CS edges arrive as 1-cycle pulses.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DEFAULT_WIDTH
) (
  input  logic                  sysClk_i,
  input  logic                  reset_ni,
  input  logic                  cs_sync_i,
  input  logic                  cs_falling_i,
  input  logic                  cs_rising_i,
  input  logic                  sclk_rising_i,
  input  logic                  sclk_falling_i,
  input  logic                  mosi_sync_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  tx_req_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  overrun_o,
  output logic                  abort_o,
  output logic                  miso_o,
  output logic                  miso_oe_o
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  spi_state_t            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  reload_pend_q, reload_pend_d;
  logic                  abort_q, abort_d;
  logic                  miso_oe_q;
  logic                  tx_req;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] rx_word;

  assign rx_word = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync_i};

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    overrun_d     = overrun_q;
    reload_pend_d = reload_pend_q;
    abort_d       = 1'b0;
    tx_req        = 1'b0;
    word_done     = 1'b0;

    // CS edges take priority over any SCLK edge arriving in the same cycle.
    if (cs_rising_i) begin
      state_d       = IDLE;
      bit_cnt_d     = '0;
      reload_pend_d = 1'b0;
      abort_d       = (bit_cnt_q != '0);
    end else if (cs_falling_i) begin
      state_d   = LOAD;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          tx_shift_d    = tx_data_i;
          tx_req        = 1'b1;
          bit_cnt_d     = '0;
          reload_pend_d = 1'b0;
          state_d       = SHIFT;
        end
        SHIFT: begin
          if (sclk_rising_i) begin
            rx_shift_d = rx_word;
            if (bit_cnt_q == LAST_BIT) begin
              word_done     = 1'b1;
              tx_req        = 1'b1;
              bit_cnt_d     = '0;
              reload_pend_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else if (sclk_falling_i) begin
            if (reload_pend_q) begin
              tx_shift_d    = tx_data_i;
              reload_pend_d = 1'b0;
            end else begin
              tx_shift_d = tx_shift_q << 1;
            end
          end
        end
        default: ;
      endcase
    end

    // A completion coinciding with an accept simply replaces the word.
    if (word_done) begin
      rx_valid_d = 1'b1;
      rx_data_d  = rx_word;
      if (rx_valid_q && !rx_ready_i) overrun_d = 1'b1;
    end else if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sysClk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      overrun_q     <= 1'b0;
      reload_pend_q <= 1'b0;
      abort_q       <= 1'b0;
      miso_oe_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      overrun_q     <= overrun_d;
      reload_pend_q <= reload_pend_d;
      abort_q       <= abort_d;
      miso_oe_q     <= ~cs_sync_i;
    end
  end

  assign tx_req_o   = tx_req;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign overrun_o  = overrun_q;
  assign abort_o    = abort_q;
  assign miso_o     = tx_shift_q[DATA_WIDTH-1] & ~cs_sync_i;
  assign miso_oe_o  = miso_oe_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: table vectors, corner sequences, random frames.
module tb_spi_slave_core;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cs_sync = 1'b1;
  logic         cs_fall = 1'b0;
  logic         cs_rise = 1'b0;
  logic         sclk_rise = 1'b0;
  logic         sclk_fall = 1'b0;
  logic         mosi = 1'b0;
  logic         rx_ready = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_req, rx_valid, overrun, abort_p, miso, miso_oe;
  logic [W-1:0] rx_data;

  int n_vec = 0;
  int n_bad = 0;
  int txreq_cnt = 0;
  logic [W-1:0] acc_q[$];

  logic [W-1:0] frame_mosi[8];
  logic [W-1:0] frame_tx[8];
  logic [W-1:0] exp_rx[8];
  logic [W-1:0] exp_miso[8];

  typedef struct {
    logic [W-1:0] mosi;
    logic [W-1:0] tx;
    logic [W-1:0] exp_rx;
    logic [W-1:0] exp_miso;
  } vec_t;
  vec_t vecs[6];

  spi_slave_core #(.DATA_WIDTH(W)) dut (
    .sysClk_i      (clk),
    .reset_ni      (rst_n),
    .cs_sync_i     (cs_sync),
    .cs_falling_i  (cs_fall),
    .cs_rising_i   (cs_rise),
    .sclk_rising_i (sclk_rise),
    .sclk_falling_i(sclk_fall),
    .mosi_sync_i   (mosi),
    .tx_data_i     (tx_data),
    .tx_req_o      (tx_req),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .overrun_o     (overrun),
    .abort_o       (abort_p),
    .miso_o        (miso),
    .miso_oe_o     (miso_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_req === 1'b1) txreq_cnt++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) acc_q.push_back(rx_data);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: reassemble a word from its MSB-first wire bit stream.
  function automatic logic [W-1:0] model_word(input logic [W-1:0] word);
    bit          q[$];
    int unsigned r;
    for (int i = W - 1; i >= 0; i--) q.push_back(word[i]);
    r = 0;
    foreach (q[j]) r = r * 2 + int'(q[j]);
    return W'(r);
  endfunction

  task automatic cs_start();
    cs_sync = 1'b0;
    cs_fall = 1'b1;
    tick();
    cs_fall = 1'b0;
    tick();
  endtask

  task automatic cs_end(input bit exp_abort);
    cs_sync = 1'b1;
    cs_rise = 1'b1;
    tick();
    cs_rise = 1'b0;
    check("abort_pulse", abort_p, exp_abort);
    check("miso_oe_off", miso_oe, 0);
    tick();
    check("abort_clear", abort_p, 0);
  endtask

  task automatic rise_bit(input logic b, input bit ready_now, output logic mb);
    mosi = b;
    tick();
    tick();
    mb = miso;
    sclk_rise = 1'b1;
    if (ready_now) rx_ready = 1'b1;
    tick();
    sclk_rise = 1'b0;
  endtask

  task automatic fall_edge();
    tick();
    tick();
    sclk_fall = 1'b1;
    tick();
    sclk_fall = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic [W-1:0] m, input logic [W-1:0] next_tx,
                           input bit chk_valid, input bit late_ready, output logic [W-1:0] mw);
    logic mb;
    tx_data = next_tx;
    mw = '0;
    for (int i = W - 1; i >= 0; i--) begin
      rise_bit(m[i], late_ready && (i == 0), mb);
      mw[i] = mb;
      if (i == 0 && chk_valid) begin
        check("rx_valid_latency", rx_valid, 1);
        check("rx_data_word", rx_data, m);
      end
      fall_edge();
    end
  endtask

  task automatic run_frame(input int n, input string name);
    logic [W-1:0] mw;
    logic [W-1:0] nxt;
    acc_q.delete();
    txreq_cnt = 0;
    rx_ready = 1'b1;
    tx_data = frame_tx[0];
    cs_start();
    check("miso_oe_on", miso_oe, 1);
    for (int k = 0; k < n; k++) begin
      nxt = (k + 1 < n) ? frame_tx[k+1] : 8'hE7;
      send_word(frame_mosi[k], nxt, 1'b1, 1'b0, mw);
      check("miso_word", mw, exp_miso[k]);
      check("valid_pulse", rx_valid, 0);
    end
    cs_end(1'b0);
    check("rx_count", acc_q.size(), n);
    for (int k = 0; k < n && k < acc_q.size(); k++) check("rx_order", acc_q[k], exp_rx[k]);
    check("tx_req_count", txreq_cnt, n + 1);
    $display("frame %s: %0d words, first mosi=0x%0h tx=0x%0h", name, n, frame_mosi[0], frame_tx[0]);
  endtask

  initial begin
    logic [W-1:0] mw;
    logic         mb;
    int           n;

    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{8'h80, 8'h01, 8'h80, 8'h01};
    vecs[4] = '{8'h01, 8'h80, 8'h01, 8'h80};
    vecs[5] = '{8'hC3, 8'h5A, 8'hC3, 8'h5A};

    // Reset state.
    #12;
    check("rst_tx_req", tx_req, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_abort", abort_p, 0);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Reset mid-frame after 3 bits, then a clean 0xC3 frame.
    tx_data = 8'h96;
    cs_start();
    for (int i = 0; i < 3; i++) begin
      rise_bit(1'b1, 1'b0, mb);
      fall_edge();
    end
    rst_n = 1'b0;
    #1;
    check("midrst_tx_req", tx_req, 0);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_abort", abort_p, 0);
    check("midrst_miso", miso, 0);
    check("midrst_miso_oe", miso_oe, 0);
    cs_sync = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    $display("reset mid-frame after 3 bits applied");
    frame_mosi[0] = 8'hC3; frame_tx[0] = 8'h0F; exp_rx[0] = 8'hC3; exp_miso[0] = 8'h0F;
    run_frame(1, "after_reset");

    // Table-driven single-word frames.
    foreach (vecs[v]) begin
      frame_mosi[0] = vecs[v].mosi;
      frame_tx[0]   = vecs[v].tx;
      exp_rx[0]     = vecs[v].exp_rx;
      exp_miso[0]   = vecs[v].exp_miso;
      run_frame(1, "table");
    end

    // Back-to-back words in one frame.
    frame_mosi[0] = 8'h01; frame_mosi[1] = 8'h02; frame_mosi[2] = 8'h03;
    frame_tx[0] = 8'hA1;   frame_tx[1] = 8'hB2;   frame_tx[2] = 8'hC4;
    exp_rx[0] = 8'h01; exp_rx[1] = 8'h02; exp_rx[2] = 8'h03;
    exp_miso[0] = 8'hA1; exp_miso[1] = 8'hB2; exp_miso[2] = 8'hC4;
    run_frame(3, "back_to_back");

    // Overrun, sticky across CS, cleared by next CS fall; then accept-on-completion.
    rx_ready = 1'b0;
    tx_data = 8'h00;
    cs_start();
    send_word(8'h11, 8'h00, 1'b1, 1'b0, mw);
    check("overrun_first", overrun, 0);
    send_word(8'h22, 8'h00, 1'b1, 1'b0, mw);
    check("overrun_set", overrun, 1);
    cs_end(1'b0);
    check("overrun_hold", overrun, 1);
    cs_start();
    check("overrun_clear", overrun, 0);
    check("valid_held", rx_valid, 1);
    check("data_held", rx_data, 8'h22);
    send_word(8'h33, 8'h00, 1'b1, 1'b1, mw);
    check("accept_no_overrun", overrun, 0);
    check("accept_valid_clear", rx_valid, 0);
    cs_end(1'b0);
    $display("overrun sequence 0x11,0x22 then same-cycle accept 0x33");

    // Abort after 5 bits, then a clean 0x5A frame.
    rx_ready = 1'b1;
    cs_start();
    for (int i = 0; i < 5; i++) begin
      rise_bit(1'b1, 1'b0, mb);
      fall_edge();
    end
    cs_end(1'b1);
    check("abort_no_valid", rx_valid, 0);
    $display("abort after 5 bits");
    frame_mosi[0] = 8'h5A; frame_tx[0] = 8'h69; exp_rx[0] = 8'h5A; exp_miso[0] = 8'h69;
    run_frame(1, "after_abort");

    // CS rise coinciding with the last sample edge.
    acc_q.delete();
    cs_start();
    for (int i = 0; i < W - 1; i++) begin
      rise_bit(1'b0, 1'b0, mb);
      fall_edge();
    end
    tick();
    tick();
    sclk_rise = 1'b1;
    cs_rise = 1'b1;
    cs_sync = 1'b1;
    tick();
    sclk_rise = 1'b0;
    cs_rise = 1'b0;
    check("collide_abort", abort_p, 1);
    check("collide_miso_oe", miso_oe, 0);
    check("collide_no_valid", rx_valid, 0);
    tick();
    check("collide_still_no_valid", rx_valid, 0);
    check("collide_rx_count", acc_q.size(), 0);
    $display("collision of cs_rising with last sclk_rising");

    // CS glitch mid-word restarts cleanly.
    tx_data = 8'h44;
    cs_start();
    for (int i = 0; i < 3; i++) begin
      rise_bit(1'b1, 1'b0, mb);
      fall_edge();
    end
    cs_fall = 1'b1;
    tick();
    cs_fall = 1'b0;
    tick();
    send_word(8'h77, 8'h00, 1'b1, 1'b0, mw);
    check("glitch_miso", mw, 8'h44);
    cs_end(1'b0);
    $display("cs glitch restart, word 0x77");

    // Random multi-word frames against the reference model.
    for (int f = 0; f < 8; f++) begin
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        frame_mosi[k] = W'($urandom);
        frame_tx[k]   = W'($urandom);
        exp_rx[k]     = model_word(frame_mosi[k]);
        exp_miso[k]   = model_word(frame_tx[k]);
      end
      run_frame(n, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
